// File: rtl/counter_pkg.sv
// Shared types for the countdown resource blocks.
//   cd_state_t : countdown controller state (IDLE, RUN, EXPIRED)
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } cd_state_t;

endpackage

// File: rtl/flex_countdown.sv
// Loadable down-counter with expiry flag and optional auto-reload.
// Consumes a programmed budget and reports exhaustion.
// Ports:
//   clk          : system clock, rising edge
//   n_rst        : asynchronous active-low reset
//   clear        : synchronous clear to IDLE (highest priority)
//   load         : capture load_val into count and reload register, start counting
//   load_val     : start / reload value
//   count_enable : decrement request, honoured only in RUN
//   reload_en    : 1 = reload at expiry and keep running, 0 = stop at zero
//   count_out    : current count (registered)
//   zero_flag    : expiry indication (registered; held in EXPIRED, 1-cycle pulse on reload)
//   busy         : 1 while in RUN (registered)
module flex_countdown
   import counter_pkg::*;
#(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    load,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   input  logic                    count_enable,
   input  logic                    reload_en,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    zero_flag,
   output logic                    busy
);

   localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
   localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

   cd_state_t                 state_q, state_d;
   logic [NUM_CNT_BITS-1:0]   count_q, count_d;
   logic [NUM_CNT_BITS-1:0]   reload_q, reload_d;
   logic                      zero_q, zero_d;
   logic                      busy_q, busy_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         count_q  <= CntZero;
         reload_q <= CntZero;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
      end
   end

   // Priority: clear > load > count_enable.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      zero_d   = zero_q;

      if (clear) begin
         // reload register deliberately survives a clear
         state_d = IDLE;
         count_d = CntZero;
         zero_d  = 1'b0;
      end else if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         if (load_val == CntZero) begin
            state_d = EXPIRED;
            zero_d  = 1'b1;
         end else begin
            state_d = RUN;
            zero_d  = 1'b0;
         end
      end else begin
         unique case (state_q)
            RUN: begin
               if (!count_enable) begin
                  zero_d = 1'b0;
               end else if (count_q == CntOne) begin
                  // reload_en only matters on this final decrement
                  zero_d = 1'b1;
                  if (reload_en) begin
                     count_d = reload_q;
                  end else begin
                     count_d = CntZero;
                     state_d = EXPIRED;
                  end
               end else begin
                  count_d = count_q - CntOne;
                  zero_d  = 1'b0;
               end
            end
            EXPIRED: begin
               count_d = CntZero;
               zero_d  = 1'b1;
            end
            IDLE: begin
               zero_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               count_d = CntZero;
               zero_d  = 1'b0;
            end
         endcase
      end

      busy_d = (state_d == RUN);
   end

   assign count_out = count_q;
   assign zero_flag = zero_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_flex_countdown.sv
module tb_flex_countdown;

   localparam int unsigned W = 4;

   logic         clk;
   logic         n_rst;
   logic         clear;
   logic         load;
   logic [W-1:0] load_val;
   logic         count_enable;
   logic         reload_en;
   logic [W-1:0] count_out;
   logic         zero_flag;
   logic         busy;

   int n_cmp;
   int n_bad;

   flex_countdown #(.NUM_CNT_BITS(W)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .load         (load),
      .load_val     (load_val),
      .count_enable (count_enable),
      .reload_en    (reload_en),
      .count_out    (count_out),
      .zero_flag    (zero_flag),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: a budget that is either idle, running or spent.
   int m_cnt;
   int m_reload;
   bit m_running;
   bit m_spent;
   bit m_zero;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_cnt <= 0; m_reload <= 0; m_running <= 0; m_spent <= 0; m_zero <= 0;
      end else if (clear) begin
         m_cnt <= 0; m_running <= 0; m_spent <= 0; m_zero <= 0;
      end else if (load) begin
         m_cnt     <= int'(load_val);
         m_reload  <= int'(load_val);
         m_running <= (load_val != 0);
         m_spent   <= (load_val == 0);
         m_zero    <= (load_val == 0);
      end else if (m_running) begin
         if (!count_enable) begin
            m_zero <= 0;
         end else if (m_cnt > 1) begin
            m_cnt  <= m_cnt - 1;
            m_zero <= 0;
         end else begin
            m_zero <= 1;
            if (reload_en) begin
               m_cnt <= m_reload;
            end else begin
               m_cnt     <= 0;
               m_running <= 0;
               m_spent   <= 1;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("model_count", int'(count_out), m_cnt);
      check("model_zero", int'(zero_flag), int'(m_zero));
      check("model_busy", int'(busy), int'(m_running));
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit c, input bit l, input int v, input bit e, input bit r);
      clear = c; load = l; load_val = W'(v); count_enable = e; reload_en = r;
   endtask

   task automatic expect3(input string name, input int c, input int z, input int b);
      check({name, "_count"}, int'(count_out), c);
      check({name, "_zero"}, int'(zero_flag), z);
      check({name, "_busy"}, int'(busy), b);
   endtask

   initial begin
      int seq3[6];
      int zq3[6];
      n_cmp = 0;
      n_bad = 0;
      n_rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      #12;
      expect3("reset", 0, 0, 0);
      n_rst = 1'b1;
      cyc();

      // Async reset mid-RUN
      drive(0, 1, 5, 0, 0);
      cyc();
      expect3("run5", 5, 0, 1);
      drive(0, 0, 0, 0, 0);
      #1 n_rst = 1'b0;
      #1;
      expect3("async_rst", 0, 0, 0);
      #1 n_rst = 1'b1;
      cyc();

      // Stop at zero
      drive(0, 1, 3, 0, 0);
      cyc(); expect3("t2_load", 3, 0, 1);
      drive(0, 0, 0, 1, 0);
      cyc(); expect3("t2_c2", 2, 0, 1);
      cyc(); expect3("t2_c1", 1, 0, 1);
      cyc(); expect3("t2_c0", 0, 1, 0);
      cyc(); expect3("t2_hold_a", 0, 1, 0);
      cyc(); expect3("t2_hold_b", 0, 1, 0);

      // Auto-reload
      drive(0, 1, 2, 0, 1);
      cyc(); expect3("t3_load", 2, 0, 1);
      drive(0, 0, 0, 1, 1);
      seq3 = '{1, 2, 1, 2, 1, 2};
      zq3  = '{0, 1, 0, 1, 0, 1};
      for (int i = 0; i < 6; i++) begin
         cyc();
         expect3($sformatf("t3_step%0d", i), seq3[i], zq3[i], 1);
      end

      // Enable with gaps
      drive(0, 1, 15, 0, 0);
      cyc(); expect3("t4_load", 15, 0, 1);
      drive(0, 0, 0, 1, 0); cyc(); expect3("t4_e1", 14, 0, 1);
      drive(0, 0, 0, 0, 0); cyc(); expect3("t4_e0", 14, 0, 1);
      drive(0, 0, 0, 1, 0); cyc(); expect3("t4_e1b", 13, 0, 1);

      // Priority
      drive(1, 1, 7, 0, 0); cyc(); expect3("t5_clr_ld", 0, 0, 0);
      drive(0, 1, 4, 0, 0); cyc(); expect3("t5_ld4", 4, 0, 1);
      drive(0, 1, 9, 1, 0); cyc(); expect3("t5_ld_en", 9, 0, 1);
      drive(0, 0, 0, 1, 0); cyc(); expect3("t5_after", 8, 0, 1);

      // Load zero goes straight to expired
      drive(0, 1, 0, 0, 0); cyc(); expect3("t6_load0", 0, 1, 0);
      drive(0, 0, 0, 1, 1); cyc(); expect3("t6_hold", 0, 1, 0);
      drive(1, 0, 0, 0, 0); cyc(); expect3("t6_clear", 0, 0, 0);
      drive(0, 0, 0, 1, 0); cyc(); expect3("t6_idle_en", 0, 0, 0);

      // Randomized traffic, checked every cycle by the model compare
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 11) == 0),
               (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15))),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) == 1));
         cyc();
      end

      drive(0, 0, 0, 0, 0);
      cyc();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
